// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter
//
// Shares the single data RAM port between instruction fetch (IF) and the
// MEM-stage load/store path. A three-state controller (IDLE -> ISSUE -> RESP)
// grants one requester per access, registers the RAM command for one cycle,
// captures the read data, and returns a one-cycle done/valid strobe three
// cycles after the request was sampled. Data accesses have priority.
//
// Optional feature macro: ARB_FAIR_EN
//   When defined, a 3-bit fairness counter limits consecutive MEM grants made
//   while a fetch is waiting to FAIR_MAX, after which IF wins once.
//   When undefined, arbitration is strict MEM priority and no counter exists.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   if_req/if_addr    fetch request (held until inst_valid) and byte address
//   if_flush          abandon the fetch currently granted
//   inst_o/inst_valid fetched word and its one-cycle strobe
//   mem_req/mem_we    data request (held until mem_done), 1 = store
//   mem_addr/mem_sel  data byte address and byte enables
//   mem_wdata         store data
//   mem_rdata         load result
//   mem_done          one-cycle completion strobe
//   ram_ce/ram_we     registered RAM command
//   ram_addr/ram_sel  RAM address and byte enables (sel is 0 for reads)
//   ram_wdata         RAM write data
//   ram_rdata         RAM read data, valid the cycle after the command
//   stallreq_if/_mem  combinational stall requests toward ctrl
module ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int FAIR_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    state_t r_state;
    state_t w_state_nxt;
    gnt_t   r_gnt;
    logic   r_store;
    logic   r_if_kill;

    logic   w_mem_elig;
    logic   w_if_elig;
    logic   w_if_wins;
    logic   w_grant_mem;
    logic   w_grant_if;
    logic   w_if_drop;

`ifdef ARB_FAIR_EN
    logic [2:0] r_fair_cnt;
`endif

    // A requester whose strobe is high this cycle is about to drop or change
    // its request, so it is masked to avoid repeating the completed access.
    assign w_mem_elig   = mem_req & ~mem_done;
    assign w_if_elig    = if_req  & ~inst_valid;

    assign stallreq_mem = mem_req & ~mem_done;
    assign stallreq_if  = if_req  & ~inst_valid;

    // Fetch response is discarded if a flush was seen in ISSUE or is seen now.
    assign w_if_drop    = r_if_kill | if_flush;

`ifdef ARB_FAIR_EN
    assign w_if_wins = w_if_elig & (~w_mem_elig | (r_fair_cnt == 3'(FAIR_MAX)));
`else
    assign w_if_wins = w_if_elig & ~w_mem_elig;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_if_wins) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (w_mem_elig) begin
                    w_grant_mem = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command, response and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_sel    <= '0;
            ram_wdata  <= '0;
            mem_rdata  <= '0;
            mem_done   <= 1'b0;
            inst_o     <= '0;
            inst_valid <= 1'b0;
            r_gnt      <= GNT_IF;
            r_store    <= 1'b0;
            r_if_kill  <= 1'b0;
        end else begin
            mem_done   <= 1'b0;
            inst_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_if_kill <= 1'b0;
                    if (w_grant_mem) begin
                        ram_ce    <= 1'b1;
                        ram_we    <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_sel   <= mem_we ? mem_sel : 4'b0000;
                        ram_wdata <= mem_wdata;
                        r_gnt     <= GNT_MEM;
                        r_store   <= mem_we;
                    end else if (w_grant_if) begin
                        ram_ce    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_sel   <= 4'b0000;
                        r_gnt     <= GNT_IF;
                        r_store   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    ram_ce  <= 1'b0;
                    ram_we  <= 1'b0;
                    ram_sel <= 4'b0000;
                    if ((r_gnt == GNT_IF) && if_flush) begin
                        r_if_kill <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (r_gnt == GNT_MEM) begin
                        if (!r_store) begin
                            mem_rdata <= ram_rdata;
                        end
                        mem_done <= 1'b1;
                    end else if (!w_if_drop) begin
                        inst_o     <= ram_rdata;
                        inst_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_FAIR_EN
    // Counts MEM grants taken while a fetch waits; saturates at FAIR_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fair_cnt <= '0;
        end else if (w_grant_if) begin
            r_fair_cnt <= '0;
        end else if (w_grant_mem && w_if_elig && (r_fair_cnt != 3'(FAIR_MAX))) begin
            r_fair_cnt <= r_fair_cnt + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int FAIR_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] inst_o;
    logic              inst_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              stallreq_if;
    logic              stallreq_mem;

    int n_vec = 0;
    int n_err = 0;
    int ce_cnt = 0;
    logic ram_init;
    logic [31:0] ram_mem [0:1023];
    logic [31:0] shadow  [0:1023];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FAIR_MAX(FAIR_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .inst_o(inst_o), .inst_valid(inst_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    function automatic logic [31:0] ram_seed(int unsigned i);
        return (i == 4) ? 32'hDEADBEEF : {16'hC0DE ^ 16'(i), 16'(i * 7 + 3)};
    endfunction

    // Synchronous RAM: data appears the cycle after the command.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= ram_seed(i);
            ram_rdata <= '0;
        end else if (ram_ce) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) ram_mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= ram_mem[ram_addr[11:2]];
        end
    end

    always @(posedge clk) if (ram_ce) ce_cnt++;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_init = 1'b1;
        if_req = 0; if_addr = '0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
        #2;
        n_vec++;
        if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, mem_rdata, mem_done,
             inst_o, inst_valid, stallreq_if, stallreq_mem} !== '0) begin
            n_err++; $display("FAIL reset_now ram_ce=%b mem_done=%b inst_valid=%b ram_addr=%0h exp all 0",
                              ram_ce, mem_done, inst_valid, ram_addr);
        end
        repeat (3) nxt();
        ram_init = 1'b0; rst = 1'b0;
        nxt();
        n_vec++;
        if ({ram_ce, mem_done, inst_valid, mem_rdata, inst_o} !== '0) begin
            n_err++; $display("FAIL reset_release ram_ce=%b mem_done=%b inst_valid=%b exp 0", ram_ce, mem_done, inst_valid);
        end
    endtask

    task automatic test_single_load();
        nxt(); // cycle 0
        mem_req = 1; mem_we = 0; mem_addr = 12'h010; mem_sel = 4'hF; mem_wdata = '0; #1;
        n_vec++;
        if ({stallreq_mem, ram_ce} !== 2'b10) begin
            n_err++; $display("FAIL load_c0 stall/ce act=%b exp=10", {stallreq_mem, ram_ce});
        end
        nxt(); // cycle 1
        n_vec++;
        if ({ram_ce, ram_we, ram_addr, ram_sel, stallreq_mem} !== {1'b1, 1'b0, 12'h010, 4'h0, 1'b1}) begin
            n_err++; $display("FAIL load_cmd ce=%b we=%b addr=%0h sel=%0h stall=%b exp 1 0 010 0 1",
                              ram_ce, ram_we, ram_addr, ram_sel, stallreq_mem);
        end
        nxt(); // cycle 2
        n_vec++;
        if ({ram_ce, mem_done, stallreq_mem} !== 3'b001) begin
            n_err++; $display("FAIL load_c2 ce/done/stall act=%b exp=001", {ram_ce, mem_done, stallreq_mem});
        end
        nxt(); // cycle 3
        n_vec++;
        if ({mem_done, stallreq_mem} !== 2'b10 || mem_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL load_done done/stall=%b rdata=%h exp 10 deadbeef", {mem_done, stallreq_mem}, mem_rdata);
        end
        nxt(); // cycle 4
        mem_req = 0; #1;
        n_vec++;
        if ({mem_done, ram_ce} !== 2'b00) begin
            n_err++; $display("FAIL load_after done/ce act=%b exp=00", {mem_done, ram_ce});
        end
    endtask

    task automatic test_collision();
        nxt(); // cycle 0
        mem_req = 1; mem_we = 1; mem_addr = 12'h020; mem_sel = 4'hF; mem_wdata = 32'h12345678;
        if_req = 1; if_addr = 12'h020; #1;
        n_vec++;
        if ({stallreq_if, stallreq_mem} !== 2'b11) begin
            n_err++; $display("FAIL coll_stall act=%b exp=11", {stallreq_if, stallreq_mem});
        end
        nxt(); // cycle 1
        n_vec++;
        if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata} !== {1'b1, 1'b1, 12'h020, 4'hF, 32'h12345678}) begin
            n_err++; $display("FAIL coll_store_cmd ce=%b we=%b addr=%0h sel=%0h wdata=%h exp 1 1 020 f 12345678",
                              ram_ce, ram_we, ram_addr, ram_sel, ram_wdata);
        end
        nxt(); nxt(); // cycle 3
        n_vec++;
        if ({mem_done, inst_valid, stallreq_if} !== 3'b101 || mem_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL coll_mem_done done/valid/stall_if=%b rdata=%h exp 101 deadbeef",
                              {mem_done, inst_valid, stallreq_if}, mem_rdata);
        end
        nxt(); // cycle 4
        mem_req = 0; mem_we = 0; #1;
        n_vec++;
        if ({ram_ce, ram_we, ram_addr, ram_sel} !== {1'b1, 1'b0, 12'h020, 4'h0}) begin
            n_err++; $display("FAIL coll_if_cmd ce=%b we=%b addr=%0h sel=%0h exp 1 0 020 0", ram_ce, ram_we, ram_addr, ram_sel);
        end
        nxt(); nxt(); // cycle 6
        n_vec++;
        if ({inst_valid, stallreq_if} !== 2'b10 || inst_o !== 32'h12345678) begin
            n_err++; $display("FAIL coll_fetch valid/stall=%b inst=%h exp 10 12345678", {inst_valid, stallreq_if}, inst_o);
        end
        nxt(); // cycle 7
        if_req = 0; #1;
        n_vec++;
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL coll_after valid act=%b exp=0", inst_valid);
        end
    endtask

    task automatic test_flush();
        nxt(); // cycle 0
        if_req = 1; if_addr = 12'h040;
        nxt(); // cycle 1 (ISSUE)
        n_vec++;
        if ({ram_ce, ram_addr} !== {1'b1, 12'h040}) begin
            n_err++; $display("FAIL flush_cmd ce=%b addr=%0h exp 1 040", ram_ce, ram_addr);
        end
        if_flush = 1;
        nxt(); // cycle 2
        if_flush = 0; if_req = 0;
        nxt(); // cycle 3
        n_vec++;
        if (inst_valid !== 1'b0 || inst_o !== 32'h12345678) begin
            n_err++; $display("FAIL flush_drop valid=%b inst=%h exp 0 12345678", inst_valid, inst_o);
        end
        nxt(); // cycle 4
        if_req = 1; if_addr = 12'h044;
        nxt(); nxt(); nxt(); // cycle 7
        n_vec++;
        if (inst_valid !== 1'b1 || inst_o !== ram_seed(17)) begin
            n_err++; $display("FAIL flush_next valid=%b inst=%h exp 1 %h", inst_valid, inst_o, ram_seed(17));
        end
        nxt();
        if_req = 0;
    endtask

    task automatic test_back_to_back();
        int snap;
        nxt(); // cycle 0
        snap = ce_cnt;
        mem_req = 1; mem_we = 0; mem_addr = 12'h010; mem_sel = 4'h3;
        nxt(); nxt(); nxt(); // cycle 3
        n_vec++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL b2b_first done=%b rdata=%h exp 1 deadbeef", mem_done, mem_rdata);
        end
        nxt(); // cycle 4
        n_vec++;
        if (ram_ce !== 1'b0) begin
            n_err++; $display("FAIL b2b_dup_ce act=%b exp=0", ram_ce);
        end
        mem_addr = 12'h014;
        nxt(); nxt(); // cycle 6
        n_vec++;
        if (mem_done !== 1'b0) begin
            n_err++; $display("FAIL b2b_early_done act=%b exp=0", mem_done);
        end
        nxt(); // cycle 7
        n_vec++;
        if (mem_done !== 1'b1 || mem_rdata !== ram_seed(5)) begin
            n_err++; $display("FAIL b2b_second done=%b rdata=%h exp 1 %h", mem_done, mem_rdata, ram_seed(5));
        end
        nxt(); // cycle 8
        mem_req = 0;
        n_vec++;
        if (ce_cnt - snap !== 2) begin
            n_err++; $display("FAIL b2b_ce_pulses act=%0d exp=2", ce_cnt - snap);
        end
    endtask

    task automatic test_async_reset();
        int snap;
        logic seen;
        nxt(); // cycle 0
        mem_req = 1; mem_we = 0; mem_addr = 12'h010;
        nxt(); nxt(); // cycle 2 (RESP)
        #2; rst = 1'b1; #1;
        n_vec++;
        if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, mem_done, mem_rdata, inst_valid, inst_o} !== '0) begin
            n_err++; $display("FAIL arst_clear ce=%b addr=%0h done=%b rdata=%h valid=%b inst=%h exp all 0",
                              ram_ce, ram_addr, mem_done, mem_rdata, inst_valid, inst_o);
        end
        mem_req = 0;
        nxt(); nxt();
        rst = 1'b0;
        snap = ce_cnt; seen = 1'b0;
        repeat (6) begin
            nxt();
            seen = seen | mem_done | inst_valid;
        end
        n_vec++;
        if (seen !== 1'b0 || ce_cnt != snap) begin
            n_err++; $display("FAIL arst_no_strobe strobe=%b ce_pulses=%0d exp 0 0", seen, ce_cnt - snap);
        end
    endtask

    // Reference model: serialised accesses tracked by cycle numbers.
    task automatic test_random();
        int free_at, iss, ms, vs, gcyc;
        logic own_if, kill, ld, e_done, e_valid, e_ce, mem_el, if_el, pick_if, pend_done, pend_valid;
        logic [31:0] pm, pi, exp_mr, exp_io;
        logic [11:0] ca;
        logic cwe;
        logic [3:0] csel;
        logic [31:0] cwd;
`ifdef ARB_FAIR_EN
        int fc = 0;
`endif
        for (int i = 0; i < 1024; i++) shadow[i] = ram_mem[i];
        free_at = 0; iss = -10; ms = -10; vs = -10; gcyc = -10;
        own_if = 0; kill = 0; ld = 0; pend_done = 0; pend_valid = 0;
        pm = '0; pi = '0; exp_mr = '0; exp_io = '0;
        ca = '0; cwe = 0; csel = '0; cwd = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            nxt();
            if (pend_done || !mem_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    mem_req = 1; mem_we = 1'($urandom); mem_addr = 12'($urandom_range(0, 63));
                    mem_sel = 4'($urandom); mem_wdata = $urandom;
                end else mem_req = 0;
            end
            if (pend_valid || !if_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    if_req = 1; if_addr = 12'($urandom_range(0, 63));
                end else if_req = 0;
            end
            if_flush = ($urandom_range(0, 7) == 0);
            #1;
            e_done  = (ms == cyc);
            e_valid = (vs == cyc) && !kill;
            e_ce    = (iss == cyc);
            if (own_if && (cyc == gcyc + 1 || cyc == gcyc + 2) && if_flush) kill = 1;
            if (e_done && ld) exp_mr = pm;
            if (e_valid) exp_io = pi;
            n_vec++;
            if ({mem_done, inst_valid, ram_ce} !== {e_done, e_valid, e_ce}) begin
                n_err++; $display("FAIL rnd_strobes cyc=%0d done/valid/ce act=%b exp=%b", cyc,
                                  {mem_done, inst_valid, ram_ce}, {e_done, e_valid, e_ce});
            end
            n_vec++;
            if (mem_rdata !== exp_mr || inst_o !== exp_io) begin
                n_err++; $display("FAIL rnd_data cyc=%0d rdata=%h inst=%h exp %h %h", cyc, mem_rdata, inst_o, exp_mr, exp_io);
            end
            n_vec++;
            if ({stallreq_mem, stallreq_if} !== {mem_req && !e_done, if_req && !e_valid}) begin
                n_err++; $display("FAIL rnd_stall cyc=%0d act=%b exp=%b", cyc, {stallreq_mem, stallreq_if},
                                  {mem_req && !e_done, if_req && !e_valid});
            end
            if (e_ce) begin
                n_vec++;
                if ({ram_we, ram_addr, ram_sel} !== {cwe, ca, csel} || (cwe && ram_wdata !== cwd)) begin
                    n_err++; $display("FAIL rnd_cmd cyc=%0d we=%b addr=%0h sel=%0h wd=%h exp %b %0h %0h %h",
                                      cyc, ram_we, ram_addr, ram_sel, ram_wdata, cwe, ca, csel, cwd);
                end
            end
            if (cyc >= free_at) begin
                mem_el  = mem_req && !e_done;
                if_el   = if_req && !e_valid;
                pick_if = if_el && !mem_el;
`ifdef ARB_FAIR_EN
                if (mem_el && if_el && fc == FAIR_MAX) pick_if = 1;
`endif
                if (pick_if) begin
                    own_if = 1; kill = 0; gcyc = cyc; vs = cyc + 3;
                    ca = if_addr; cwe = 0; csel = '0;
                    pi = shadow[if_addr[11:2]];
`ifdef ARB_FAIR_EN
                    fc = 0;
`endif
                end else if (mem_el) begin
                    own_if = 0; gcyc = cyc; ms = cyc + 3;
                    ca = mem_addr; cwe = mem_we; csel = mem_we ? mem_sel : 4'h0; cwd = mem_wdata;
                    ld = !mem_we;
                    if (ld) pm = shadow[mem_addr[11:2]];
                    else for (int b = 0; b < 4; b++)
                        if (mem_sel[b]) shadow[mem_addr[11:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
`ifdef ARB_FAIR_EN
                    if (if_el && fc < FAIR_MAX) fc++;
`endif
                end
                if (pick_if || mem_el) begin
                    iss = cyc + 1; free_at = cyc + 3;
                end
            end
            pend_done = e_done; pend_valid = e_valid;
        end
        mem_req = 0; if_req = 0; if_flush = 0;
        repeat (4) nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_load();
        test_collision();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
